// File: rtl/riscv_core_dcache_wb_if.sv
// ---------------------------------------------------------------------------
// riscv_core_dcache_wb_if
// Bundles the core-side access port and the memory-side refill/writeback
// port of the write-back data cache.
//
// Handshake rules:
//   core   : i_req qualifies i_we/i_lr/i_sc/i_size/i_addr/i_wdata. The access
//            completes on the rising edge of a cycle in which o_stall is low.
//            While o_stall is high the core holds every request input stable.
//   memory : o_mem_read_req / o_mem_write_req stay high, with address and
//            block stable, until the matching *_done is sampled high on a
//            rising edge. Done may be high in the same cycle the request
//            first rises. Done is ignored while no transfer of that kind is
//            pending.
//
// Modports: slave = cache side, master = core/memory driver side.
// ---------------------------------------------------------------------------
interface riscv_core_dcache_wb_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int LINE_WIDTH = 256
);
  // core access port
  logic                  i_req;
  logic                  i_we;
  logic                  i_lr;
  logic                  i_sc;
  logic [1:0]            i_size;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_wdata;
  logic                  o_stall;
  logic [DATA_WIDTH-1:0] o_rdata;
  logic                  o_fault;
  // refill port
  logic                  o_mem_read_req;
  logic [ADDR_WIDTH-1:0] o_mem_read_address;
  logic                  i_mem_read_done;
  logic [LINE_WIDTH-1:0] i_block_from_axi;
  // writeback port
  logic                  o_mem_write_req;
  logic [ADDR_WIDTH-1:0] o_mem_write_address;
  logic [LINE_WIDTH-1:0] o_mem_write_block;
  logic                  i_mem_write_done;

  modport slave (
    input  i_req, i_we, i_lr, i_sc, i_size, i_addr, i_wdata,
    input  i_mem_read_done, i_block_from_axi, i_mem_write_done,
    output o_stall, o_rdata, o_fault,
    output o_mem_read_req, o_mem_read_address,
    output o_mem_write_req, o_mem_write_address, o_mem_write_block
  );

  modport master (
    output i_req, i_we, i_lr, i_sc, i_size, i_addr, i_wdata,
    output i_mem_read_done, i_block_from_axi, i_mem_write_done,
    input  o_stall, o_rdata, o_fault,
    input  o_mem_read_req, o_mem_read_address,
    input  o_mem_write_req, o_mem_write_address, o_mem_write_block
  );
endinterface

// File: rtl/riscv_core_dcache_wb.sv
// ---------------------------------------------------------------------------
// riscv_core_dcache_wb
// Write-back, write-allocate data cache, 1- or 2-way set associative, with
// an LR/SC reservation register.
//
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   bus (slave)   : core access port + refill/writeback port
//                   (see riscv_core_dcache_wb_if)
//   o_dbg_state   : FSM state (0 IDLE, 1 WRITEBACK, 2 REFILL, 3 RESPOND)
//
// Hits complete combinationally in IDLE. A miss stalls, optionally writes
// the dirty victim back, refills the victim way and then completes the
// original access as a hit in RESPOND.
// ---------------------------------------------------------------------------
module riscv_core_dcache_wb #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int LINE_WIDTH = 256,
  parameter int SETS       = 64,
  parameter int WAYS       = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  riscv_core_dcache_wb_if.slave        bus,
  output logic [1:0]                   o_dbg_state
);
  localparam int OFF_W   = $clog2(LINE_WIDTH / 8);
  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_W   = ADDR_WIDTH - OFF_W - IDX_W;
  localparam int LADDR_W = ADDR_WIDTH - OFF_W;
  localparam int SH_W    = OFF_W + 3;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_REFILL, S_RESPOND} state_t;

  // cache arrays
  logic [LINE_WIDTH-1:0] data_q  [SETS][WAYS];
  logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
  logic                  valid_q [SETS][WAYS];
  logic                  dirty_q [SETS][WAYS];
  logic                  lru_q   [SETS];        // way to victimise next

  // control state
  state_t               state_q, state_d;
  logic                 way_q, way_d;           // victim way of the miss in flight
  logic                 wr_req_q, wr_req_d;
  logic                 rd_req_q, rd_req_d;
  logic                 resv_valid_q, resv_valid_d;
  logic [LADDR_W-1:0]   resv_line_q, resv_line_d;

  // address decode
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic [OFF_W-1:0]   off;
  logic [LADDR_W-1:0] line_addr;
  logic [SH_W-1:0]    shamt;
  assign idx       = bus.i_addr[OFF_W +: IDX_W];
  assign tag       = bus.i_addr[ADDR_WIDTH-1 -: TAG_W];
  assign off       = bus.i_addr[OFF_W-1:0];
  assign line_addr = bus.i_addr[ADDR_WIDTH-1:OFF_W];
  assign shamt     = {off, 3'b000};

  // lookup and victim selection
  logic hit, hit_way, vict_way;
  always_comb begin
    hit      = 1'b0;
    hit_way  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = 1'(w);
      end
    end
    vict_way = 1'b0;
    if (WAYS == 2) begin
      if (!valid_q[idx][0])           vict_way = 1'b0;
      else if (!valid_q[idx][WAYS-1]) vict_way = 1'b1;
      else                            vict_way = lru_q[idx];
    end
  end

  // access classification; requests are only serviced in IDLE and RESPOND
  logic [2:0] align_mask;
  logic       misaligned, active, sc_ok, sc_fail, is_store, complete, miss;
  assign align_mask = 3'((4'd1 << bus.i_size) - 4'd1);
  assign misaligned = |(bus.i_addr[2:0] & align_mask);
  assign active     = bus.i_req && !misaligned &&
                      (state_q == S_IDLE || state_q == S_RESPOND);
  assign sc_ok      = resv_valid_q && (resv_line_q == line_addr);
  assign sc_fail    = bus.i_sc && !sc_ok;
  assign is_store   = bus.i_we || bus.i_sc;
  assign complete   = active && !sc_fail && hit;
  assign miss       = active && !sc_fail && !hit && (state_q == S_IDLE);

  // byte-lane extraction and merge within the selected line
  logic [DATA_WIDTH-1:0] size_mask, load_data;
  logic [LINE_WIDTH-1:0] hit_line, shifted, line_mask, store_line, new_line;
  always_comb begin
    size_mask = '0;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (b < (1 << bus.i_size)) size_mask[b*8 +: 8] = 8'hFF;
    end
    hit_line   = data_q[idx][hit_way];
    shifted    = hit_line >> shamt;
    load_data  = shifted[DATA_WIDTH-1:0] & size_mask;
    line_mask  = LINE_WIDTH'(size_mask) << shamt;
    store_line = LINE_WIDTH'(bus.i_wdata & size_mask) << shamt;
    new_line   = (hit_line & ~line_mask) | store_line;
  end

  // a successful SC is a store, so it returns 0 through the default
  logic [DATA_WIDTH-1:0] rdata;
  always_comb begin
    rdata = '0;
    if (active && sc_fail)            rdata = DATA_WIDTH'(1);
    else if (complete && !is_store)   rdata = load_data;
  end

  logic wb_done, rf_done;
  assign wb_done = (state_q == S_WRITEBACK) && bus.i_mem_write_done;
  assign rf_done = (state_q == S_REFILL)    && bus.i_mem_read_done;

  assign bus.o_rdata             = rdata;
  assign bus.o_fault             = bus.i_req && misaligned;
  assign bus.o_stall             = miss || state_q == S_WRITEBACK || state_q == S_REFILL;
  assign bus.o_mem_write_req     = wr_req_q;
  assign bus.o_mem_read_req      = rd_req_q;
  assign bus.o_mem_read_address  = {line_addr, {OFF_W{1'b0}}};
  assign bus.o_mem_write_address = {tag_q[idx][way_q], idx, {OFF_W{1'b0}}};
  assign bus.o_mem_write_block   = data_q[idx][way_q];
  assign o_dbg_state             = state_q;

  // next-state logic
  always_comb begin
    state_d      = state_q;
    way_d        = way_q;
    wr_req_d     = wr_req_q;
    rd_req_d     = rd_req_q;
    resv_valid_d = resv_valid_q;
    resv_line_d  = resv_line_q;
    case (state_q)
      S_IDLE: begin
        if (miss) begin
          way_d = vict_way;
          if (valid_q[idx][vict_way] && dirty_q[idx][vict_way]) begin
            state_d  = S_WRITEBACK;
            wr_req_d = 1'b1;
          end else begin
            state_d  = S_REFILL;
            rd_req_d = 1'b1;
          end
        end
      end
      S_WRITEBACK: begin
        if (bus.i_mem_write_done) begin
          state_d  = S_REFILL;
          wr_req_d = 1'b0;
          rd_req_d = 1'b1;
        end
      end
      S_REFILL: begin
        if (bus.i_mem_read_done) begin
          state_d  = S_RESPOND;
          rd_req_d = 1'b0;
          // the reserved line loses its reservation when it is replaced
          if (valid_q[idx][way_q] && resv_line_q == {tag_q[idx][way_q], idx})
            resv_valid_d = 1'b0;
        end
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (active && bus.i_sc && (sc_fail || hit)) begin
      resv_valid_d = 1'b0;
    end else if (complete && bus.i_lr && !is_store) begin
      resv_valid_d = 1'b1;
      resv_line_d  = line_addr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      way_q        <= 1'b0;
      wr_req_q     <= 1'b0;
      rd_req_q     <= 1'b0;
      resv_valid_q <= 1'b0;
      resv_line_q  <= '0;
    end else begin
      state_q      <= state_d;
      way_q        <= way_d;
      wr_req_q     <= wr_req_d;
      rd_req_q     <= rd_req_d;
      resv_valid_q <= resv_valid_d;
      resv_line_q  <= resv_line_d;
    end
  end

  // line status bits; reset wins over any pending refill or writeback
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < SETS; s++) begin
        lru_q[s] <= 1'b0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
        end
      end
    end else begin
      if (complete) begin
        if (WAYS == 2) lru_q[idx] <= ~hit_way;
        if (is_store)  dirty_q[idx][hit_way] <= 1'b1;
      end
      if (wb_done) dirty_q[idx][way_q] <= 1'b0;
      if (rf_done) begin
        valid_q[idx][way_q] <= 1'b1;
        dirty_q[idx][way_q] <= 1'b0;
      end
    end
  end

  // line data and tags carry no reset; valid bits qualify them
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (complete && is_store) data_q[idx][hit_way] <= new_line;
      if (rf_done) begin
        data_q[idx][way_q] <= bus.i_block_from_axi;
        tag_q[idx][way_q]  <= tag;
      end
    end
  end
endmodule

// File: tb/tb_riscv_core_dcache_wb.sv
module tb_riscv_core_dcache_wb;
  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  riscv_core_dcache_wb_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .LINE_WIDTH(256)) bus ();

  riscv_core_dcache_wb #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .LINE_WIDTH(256), .SETS(64), .WAYS(2)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // backing : what main memory holds
  // coherent: what the core must observe (memory plus every completed store)
  // lru_list: resident lines, most recently used first
  logic [255:0]    backing  [longint unsigned];
  logic [255:0]    coherent [longint unsigned];
  bit              dirty_m  [longint unsigned];
  longint unsigned lru_list [$];
  bit              resv_v;
  longint unsigned resv_l;
  logic [63:0]     last_rd;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic void ensure_line(longint unsigned l);
    logic [255:0] v;
    if (!coherent.exists(l)) begin
      v = rand_line();
      coherent[l] = v;
      backing[l]  = v;
    end
  endfunction

  // ---------------- driver ----------------
  task automatic do_access(input bit we, input bit lr, input bit sc,
                           input logic [1:0] sz, input logic [63:0] addr,
                           input logic [63:0] wd);
    longint unsigned l, wb_line, ra;
    int              set_i, cnt, pos, lat_w, lat_r, cycles;
    bit              mis, exp_hit, exp_wb, chk_rd, seen_wb, seen_rd, finished;
    logic [255:0]    wb_blk, ln;
    logic [63:0]     exp_rd;

    l       = addr >> 5;
    set_i   = int'(l % 64);
    mis     = (addr % (64'd1 << sz)) != 0;
    exp_hit = 1'b1;
    exp_wb  = 1'b0;
    chk_rd  = 1'b0;
    exp_rd  = '0;
    wb_line = 0;
    wb_blk  = '0;

    if (!mis) begin
      ensure_line(l);
      if (sc && !(resv_v && resv_l == l)) begin
        exp_rd = 64'd1;
        chk_rd = 1'b1;
        resv_v = 1'b0;
      end else begin
        pos = -1;
        for (int i = 0; i < lru_list.size(); i++) if (lru_list[i] == l) pos = i;
        exp_hit = (pos >= 0);
        if (exp_hit) lru_list.delete(pos);
        else begin
          cnt = 0;
          for (int i = 0; i < lru_list.size(); i++) if (int'(lru_list[i] % 64) == set_i) cnt++;
          if (cnt == 2) begin
            for (int i = lru_list.size() - 1; i >= 0; i--)
              if (pos < 0 && int'(lru_list[i] % 64) == set_i) pos = i;
            wb_line = lru_list[pos];
            lru_list.delete(pos);
            if (dirty_m.exists(wb_line) && dirty_m[wb_line]) begin
              exp_wb = 1'b1;
              wb_blk = coherent[wb_line];
            end
            dirty_m[wb_line] = 1'b0;
            if (resv_v && resv_l == wb_line) resv_v = 1'b0;
          end
        end
        lru_list.push_front(l);
        ln = coherent[l];
        if (we || sc) begin
          for (int b = 0; b < (1 << sz); b++) ln[(int'(addr[4:0]) + b)*8 +: 8] = wd[b*8 +: 8];
          coherent[l] = ln;
          dirty_m[l]  = 1'b1;
        end else begin
          for (int b = 0; b < (1 << sz); b++) exp_rd[b*8 +: 8] = ln[(int'(addr[4:0]) + b)*8 +: 8];
          chk_rd = 1'b1;
          if (lr) begin
            resv_v = 1'b1;
            resv_l = l;
          end
        end
        if (sc) begin
          resv_v = 1'b0;
          exp_rd = '0;
          chk_rd = 1'b1;
        end
      end
    end

    @(posedge clk); #1;
    bus.i_req   = 1'b1;
    bus.i_we    = we;
    bus.i_lr    = lr;
    bus.i_sc    = sc;
    bus.i_size  = sz;
    bus.i_addr  = addr;
    bus.i_wdata = wd;
    cycles   = 0;
    finished = 1'b0;
    seen_wb  = 1'b0;
    seen_rd  = 1'b0;
    lat_w    = 0;
    lat_r    = 0;
    while (!finished) begin
      @(negedge clk);
      if (cycles == 0) begin
        check_eq("fault", bus.o_fault, mis);
        check_eq("stall_first", bus.o_stall, !mis && !exp_hit);
      end
      check_eq("one_req", bus.o_mem_read_req && bus.o_mem_write_req, 1'b0);
      if (bus.o_mem_write_req) begin
        if (!seen_wb) lat_w = $urandom_range(0, 2);
        seen_wb = 1'b1;
        check_eq("wb_addr", bus.o_mem_write_address, wb_line << 5);
        check_eq("wb_data", bus.o_mem_write_block, wb_blk);
        if (lat_w == 0) begin
          bus.i_mem_write_done = 1'b1;
          backing[bus.o_mem_write_address >> 5] = bus.o_mem_write_block;
        end else begin
          lat_w--;
          bus.i_mem_read_done  = 1'($urandom_range(0, 1));
          bus.i_block_from_axi = rand_line();
        end
      end
      if (bus.o_mem_read_req) begin
        if (!seen_rd) lat_r = $urandom_range(0, 2);
        seen_rd = 1'b1;
        check_eq("rd_addr", bus.o_mem_read_address, l << 5);
        if (lat_r == 0) begin
          ra = bus.o_mem_read_address >> 5;
          bus.i_mem_read_done  = 1'b1;
          bus.i_block_from_axi = backing.exists(ra) ? backing[ra] : rand_line();
        end else begin
          lat_r--;
          bus.i_mem_write_done = 1'($urandom_range(0, 1));
        end
      end
      if (!bus.o_stall) begin
        last_rd = bus.o_rdata;
        if (chk_rd) check_eq("rdata", bus.o_rdata, exp_rd);
        finished = 1'b1;
      end else if (cycles > 40) begin
        check_eq("timeout", 1'b1, 1'b0);
        finished = 1'b1;
      end
      @(posedge clk); #1;
      bus.i_mem_write_done = 1'b0;
      bus.i_mem_read_done  = 1'b0;
      cycles++;
    end
    bus.i_req = 1'b0;
    bus.i_we  = 1'b0;
    bus.i_lr  = 1'b0;
    bus.i_sc  = 1'b0;
    check_eq("wb_seen", seen_wb, exp_wb);
    check_eq("rd_seen", seen_rd, !mis && !exp_hit);
  endtask

  // done pulses with no transfer pending must be ignored
  task automatic idle_spurious(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.i_mem_read_done  = 1'b1;
      bus.i_mem_write_done = 1'b1;
      bus.i_block_from_axi = rand_line();
      @(negedge clk);
      check_eq("idle_stall", bus.o_stall, 1'b0);
      check_eq("idle_noreq", bus.o_mem_read_req || bus.o_mem_write_req, 1'b0);
    end
    @(posedge clk); #1;
    bus.i_mem_read_done  = 1'b0;
    bus.i_mem_write_done = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [63:0] a, wd;
  logic [1:0]  sz;
  int          r, offv;
  bit          seen;

  initial begin
    rst = 1'b1;
    bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_lr = 1'b0; bus.i_sc = 1'b0;
    bus.i_size = 2'd0; bus.i_addr = '0; bus.i_wdata = '0;
    bus.i_mem_read_done = 1'b0; bus.i_mem_write_done = 1'b0; bus.i_block_from_axi = '0;
    resv_v = 1'b0; resv_l = 0; last_rd = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_stall", bus.o_stall, 1'b0);
    check_eq("rst_rdata", bus.o_rdata, 64'd0);
    check_eq("rst_fault", bus.o_fault, 1'b0);
    check_eq("rst_rdreq", bus.o_mem_read_req, 1'b0);
    check_eq("rst_wrreq", bus.o_mem_write_req, 1'b0);

    // cold load, byte store then word load, misaligned halfword
    do_access(0, 0, 0, 2'd3, 64'h1000, '0);
    do_access(1, 0, 0, 2'd0, 64'h1003, 64'hAB);
    do_access(0, 0, 0, 2'd2, 64'h1000, '0);
    check_eq("byte3", last_rd[31:24], 8'hAB);
    do_access(0, 0, 0, 2'd1, 64'h1001, '0);

    // dirty both ways of set 0, then a third tag forces a writeback
    do_access(1, 0, 0, 2'd3, 64'h3000, {$urandom, $urandom});
    do_access(0, 0, 0, 2'd3, 64'h5000, '0);
    do_access(0, 0, 0, 2'd0, 64'h1003, '0);
    check_eq("refetch_ab", last_rd, 64'hAB);

    // reservation: LR, successful SC, failing SC, readback
    do_access(0, 1, 0, 2'd3, 64'h2000, '0);
    do_access(0, 0, 1, 2'd3, 64'h2000, 64'h1122_3344_5566_7788);
    check_eq("sc_ok", last_rd, 64'd0);
    do_access(0, 0, 1, 2'd3, 64'h2000, 64'hDEAD_BEEF_0000_0000);
    check_eq("sc_fail", last_rd, 64'd1);
    do_access(0, 0, 0, 2'd3, 64'h2000, '0);
    check_eq("sc_data", last_rd, 64'h1122_3344_5566_7788);

    idle_spurious(3);

    // randomized traffic over a few sets and tags to provoke conflicts
    for (int n = 0; n < 300; n++) begin
      r    = $urandom_range(0, 9);
      sz   = 2'($urandom_range(0, 3));
      offv = ($urandom_range(0, 31) >> sz) << sz;
      a    = (64'($urandom_range(0, 3)) << 11) | (64'($urandom_range(0, 3)) << 5) | 64'(offv);
      wd   = {$urandom, $urandom};
      if (r == 0) begin
        if (sz == 2'd0) sz = 2'd1;
        a = a | 64'd1;
      end
      if (r == 5 && resv_v && $urandom_range(0, 1) == 1) a = (resv_l << 5) | 64'(offv);
      do_access(r >= 1 && r <= 3, r == 4, r == 5, sz, a, wd);
    end

    // reset while a refill is pending
    a = 64'h0001_2340;
    ensure_line(a >> 5);
    @(posedge clk); #1;
    bus.i_req = 1'b1; bus.i_size = 2'd3; bus.i_addr = a;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.o_mem_read_req) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check_eq("rst_reach_refill", seen, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i_req = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_state", dbg_state, 2'd0);
    check_eq("mid_rst_stall", bus.o_stall, 1'b0);
    check_eq("mid_rst_rdreq", bus.o_mem_read_req, 1'b0);
    check_eq("mid_rst_wrreq", bus.o_mem_write_req, 1'b0);
    lru_list.delete();
    dirty_m.delete();
    resv_v   = 1'b0;
    coherent = backing;
    do_access(0, 0, 0, 2'd3, a, '0);
    for (int n = 0; n < 40; n++) begin
      sz = 2'($urandom_range(0, 3));
      offv = ($urandom_range(0, 31) >> sz) << sz;
      a = (64'($urandom_range(0, 3)) << 11) | (64'($urandom_range(0, 1)) << 5) | 64'(offv);
      do_access($urandom_range(0, 1) == 1, 0, 0, sz, a, {$urandom, $urandom});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
